fdct2_4pt_core: RTL

- Forward 4-point DCT-II core for the encoder-side/reference-model path; the counterpart of the IDCT2 inverse datapath.
- Accepts one row/column of 4 signed residuals via valid/ready and computes the 4 VVC transform coefficients using an even/odd butterfly and two pipelined signed multipliers.
- Rounds, shifts, saturates, then holds the result until the consumer accepts it.
- Sits between the residual buffer and the transpose/second-stage memory.

---
 rtl/fdct2_pkg.sv | 22 ++
 rtl/fdct2_4pt_core_if.sv | 31 +++
 rtl/fdct2_mul_pipe.sv | 28 ++
 rtl/fdct2_4pt_core.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fdct2_pkg.sv
// Shared constants and types for the forward 4-point DCT-II core.
package fdct2_pkg;

  localparam int DIN_W  = 16;
  localparam int DOUT_W = 16;
  localparam int COEF_W = 8;

  localparam int BF_W   = DIN_W + 1;
  localparam int PROD_W = BF_W + COEF_W;
  localparam int ACC_W  = PROD_W + 1;

  localparam int C64 = 64;
  localparam int C83 = 83;
  localparam int C36 = 36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/fdct2_4pt_core_if.sv
// Block-in / coefficients-out handshake bundle for fdct2_4pt_core.
interface fdct2_4pt_core_if #(
  parameter int DIN_W  = fdct2_pkg::DIN_W,
  parameter int DOUT_W = fdct2_pkg::DOUT_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DIN_W-1:0]  in_x0;
  logic signed [DIN_W-1:0]  in_x1;
  logic signed [DIN_W-1:0]  in_x2;
  logic signed [DIN_W-1:0]  in_x3;
  logic [3:0]               in_shift;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DOUT_W-1:0] out_c0;
  logic signed [DOUT_W-1:0] out_c1;
  logic signed [DOUT_W-1:0] out_c2;
  logic signed [DOUT_W-1:0] out_c3;

  modport master (
    output in_valid, in_x0, in_x1, in_x2, in_x3, in_shift, out_ready,
    input  in_ready, out_valid, out_c0, out_c1, out_c2, out_c3
  );

  modport slave (
    input  in_valid, in_x0, in_x1, in_x2, in_x3, in_shift, out_ready,
    output in_ready, out_valid, out_c0, out_c1, out_c2, out_c3
  );

endinterface

// File: rtl/fdct2_mul_pipe.sv
// Signed multiplier with a single clock-enabled output register.
module fdct2_mul_pipe #(
  parameter int A_W = 17,
  parameter int B_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce_i,
  input  logic signed [A_W-1:0]     a_i,
  input  logic signed [B_W-1:0]     b_i,
  output logic signed [A_W+B_W-1:0] p_o
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] p_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q <= '0;
    end else if (ce_i) begin
      p_q <= P_W'(a_i) * P_W'(b_i);
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/fdct2_4pt_core.sv
// Forward 4-point DCT-II: even/odd butterfly, two shared multipliers issuing
// one coefficient per cycle, then round, shift, saturate and hold.
module fdct2_4pt_core
  import fdct2_pkg::*;
#(
  parameter int DIN_W  = fdct2_pkg::DIN_W,
  parameter int DOUT_W = fdct2_pkg::DOUT_W,
  parameter int COEF_W = fdct2_pkg::COEF_W
) (
  input logic             clk,
  input logic             reset,
  fdct2_4pt_core_if.slave bus
);

  localparam int BF_W   = DIN_W + 1;
  localparam int PROD_W = BF_W + COEF_W;
  localparam int ACC_W  = PROD_W + 1;

  localparam logic signed [COEF_W-1:0] K64 = COEF_W'(C64);
  localparam logic signed [COEF_W-1:0] K83 = COEF_W'(C83);
  localparam logic signed [COEF_W-1:0] K36 = COEF_W'(C36);

  localparam longint SMAX = (longint'(1) << (DOUT_W - 1)) - 1;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(SMAX);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-SMAX - 1);

  state_e                   state_q, state_d;
  logic [2:0]               k_q, k_d;
  logic                     rdy_q;
  logic                     vld_q, vld_d;
  logic [3:0]               shift_q;
  logic signed [BF_W-1:0]   e0_q, e1_q, o0_q, o1_q;
  logic signed [DOUT_W-1:0] c_q [4];

  logic                     accept;
  logic                     ce;
  logic signed [BF_W-1:0]   a0, a1;
  logic signed [COEF_W-1:0] b0, b1;
  logic signed [PROD_W-1:0] p0, p1;
  logic [1:0]               widx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    rnd, rsum, rshr;
  logic signed [DOUT_W-1:0] sat;

  // rdy_q is only set while IDLE, so it also gates acceptance to that state.
  assign accept = bus.in_valid & rdy_q;
  assign ce     = (state_q == CALC) && !k_q[2];
  // Products in the registers belong to the index issued one cycle earlier.
  assign widx   = k_q[1:0] - 2'd1;

  always_comb begin
    a0 = e0_q;
    a1 = e1_q;
    b0 = K64;
    b1 = K64;
    case (k_q[1:0])
      2'd1: begin a0 = o0_q; a1 = o1_q; b0 = K83; b1 = K36; end
      2'd3: begin a0 = o0_q; a1 = o1_q; b0 = K36; b1 = K83; end
      default: ;
    endcase
  end

  fdct2_mul_pipe #(.A_W(BF_W), .B_W(COEF_W)) u_mul0 (
    .clk(clk), .reset(reset), .ce_i(ce), .a_i(a0), .b_i(b0), .p_o(p0)
  );

  fdct2_mul_pipe #(.A_W(BF_W), .B_W(COEF_W)) u_mul1 (
    .clk(clk), .reset(reset), .ce_i(ce), .a_i(a1), .b_i(b1), .p_o(p1)
  );

  always_comb begin
    acc  = widx[1] ? (ACC_W'(p0) - ACC_W'(p1)) : (ACC_W'(p0) + ACC_W'(p1));
    rnd  = (shift_q == 4'd0) ? '0 : ((ACC_W+1)'(1) << (shift_q - 4'd1));
    rsum = (ACC_W+1)'(acc) + rnd;
    rshr = rsum >>> shift_q;
    if (rshr > SAT_MAX) begin
      sat = {1'b0, {(DOUT_W-1){1'b1}}};
    end else if (rshr < SAT_MIN) begin
      sat = {1'b1, {(DOUT_W-1){1'b0}}};
    end else begin
      sat = rshr[DOUT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = CALC;
        k_d     = '0;
      end
      CALC: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd4) begin
          state_d = OUT;
          vld_d   = 1'b1;
        end
      end
      OUT: if (bus.out_ready) begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      shift_q <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      o0_q    <= '0;
      o1_q    <= '0;
      c_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
      rdy_q   <= (state_d == IDLE);
      if (accept) begin
        shift_q <= bus.in_shift;
        e0_q    <= BF_W'(bus.in_x0) + BF_W'(bus.in_x3);
        e1_q    <= BF_W'(bus.in_x1) + BF_W'(bus.in_x2);
        o0_q    <= BF_W'(bus.in_x0) - BF_W'(bus.in_x3);
        o1_q    <= BF_W'(bus.in_x1) - BF_W'(bus.in_x2);
      end
      if (state_q == CALC && k_q != 3'd0) begin
        c_q[widx] <= sat;
      end
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_c0    = c_q[0];
  assign bus.out_c1    = c_q[1];
  assign bus.out_c2    = c_q[2];
  assign bus.out_c3    = c_q[3];

endmodule
